spi_reg_master: RTL and testbench



---
 rtl/spi_reg_master.sv | 158 +++++++++++++++
 tb/tb_spi_reg_master.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_master.sv
// SPI mode-0 register master: one {rw,addr[6:0]} byte then one data byte, MSB first.
// Command accepted on valid/ready; rsp_valid pulses once as cs_n deasserts.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// SETUP | cs_n low, rw bit on mosi, first half-period before sclk rises
// SHIFT | 16 sclk periods; miso sampled on rise, mosi advanced on fall
// HOLD  | sclk low, cs_n still low for one half-period
// GAP   | cs_n high for the minimum deassert time before cmd_ready returns
module spi_reg_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0]      LAST_BIT = 5'd15;
  localparam logic [4:0]      BIT_DONE = 5'd16;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [4:0]       r_bit, w_bit_nxt;
  logic [15:0]      r_shift, w_shift_nxt;
  logic [7:0]       r_rx, w_rx_nxt;
  logic [7:0]       r_rdata, w_rdata_nxt;
  logic             r_rw, w_rw_nxt;
  logic             r_sclk, w_sclk_nxt;
  logic             r_cs_n, w_cs_n_nxt;
  logic             r_ready, w_ready_nxt;
  logic             r_rsp, w_rsp_nxt;
  logic             w_div_tc;
  logic             w_accept;

  assign w_div_tc  = (r_div == '0);
  assign w_accept  = cmd_valid && r_ready;

  assign cmd_ready = r_ready;
  assign busy      = ~r_ready;
  assign sclk      = r_sclk;
  assign cs_n      = r_cs_n;
  // Zeros fill the shift register from the right, so mosi is 0 outside the frame.
  assign mosi      = r_shift[15];
  assign rsp_valid = r_rsp;
  assign rsp_rdata = r_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_div   <= DIV_LOAD;
      r_bit   <= '0;
      r_shift <= '0;
      r_rx    <= '0;
      r_rdata <= '0;
      r_rw    <= 1'b0;
      r_sclk  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_ready <= 1'b1;
      r_rsp   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_rx    <= w_rx_nxt;
      r_rdata <= w_rdata_nxt;
      r_rw    <= w_rw_nxt;
      r_sclk  <= w_sclk_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_ready <= w_ready_nxt;
      r_rsp   <= w_rsp_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = w_div_tc ? DIV_LOAD : r_div - 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_rx_nxt    = r_rx;
    w_rdata_nxt = r_rdata;
    w_rw_nxt    = r_rw;
    w_sclk_nxt  = r_sclk;
    w_cs_n_nxt  = r_cs_n;
    w_ready_nxt = r_ready;
    w_rsp_nxt   = 1'b0;

    case (r_state)
      IDLE: begin
        w_div_nxt = DIV_LOAD;
        if (w_accept) begin
          // Read frames send a zero data byte regardless of cmd_wdata.
          w_shift_nxt = {cmd_rw, cmd_addr, cmd_rw ? 8'h00 : cmd_wdata};
          w_rw_nxt    = cmd_rw;
          w_cs_n_nxt  = 1'b0;
          w_ready_nxt = 1'b0;
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (w_div_tc) begin
          w_sclk_nxt  = 1'b1;
          w_rx_nxt    = {r_rx[6:0], miso};
          w_bit_nxt   = '0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_div_tc) begin
          if (r_sclk) begin
            w_sclk_nxt  = 1'b0;
            w_shift_nxt = {r_shift[14:0], 1'b0};
            if (r_bit == LAST_BIT) begin
              w_bit_nxt   = BIT_DONE;
              w_state_nxt = HOLD;
            end else begin
              w_bit_nxt = r_bit + 1'b1;
            end
          end else begin
            w_sclk_nxt = 1'b1;
            w_rx_nxt   = {r_rx[6:0], miso};
          end
        end
      end
      HOLD: begin
        if (w_div_tc) begin
          w_cs_n_nxt  = 1'b1;
          w_rsp_nxt   = 1'b1;
          if (r_rw) w_rdata_nxt = r_rx;
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        if (w_div_tc) begin
          w_ready_nxt = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: CLK_DIV=4 and CLK_DIV=1 instances, SPI slave model,
// frame/timing expectations computed from the transaction timing formulas.
module tb_spi_reg_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic [1:0] cmd_valid = 2'b00;
  logic [1:0] cmd_rw = 2'b00;
  logic [1:0] cmd_ready, rsp_valid, busy, sclk, cs_n, mosi;
  logic [1:0] miso = 2'b00;
  logic [6:0] cmd_addr  [2] = '{7'h0, 7'h0};
  logic [7:0] cmd_wdata [2] = '{8'h0, 8'h0};
  logic [7:0] rsp_rdata [2];

  spi_reg_master #(.CLK_DIV(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_rw(cmd_rw[0]), .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
    .sclk(sclk[0]), .cs_n(cs_n[0]), .mosi(mosi[0]), .miso(miso[0]));

  spi_reg_master #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_rw(cmd_rw[1]), .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
    .sclk(sclk[1]), .cs_n(cs_n[1]), .mosi(mosi[1]), .miso(miso[1]));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dv(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Event logs, written only by the monitor below.
  int acc_n [2] = '{0, 0};
  int fall_n [2] = '{0, 0};
  int crise_n [2] = '{0, 0};
  int rsp_n [2] = '{0, 0};
  int rdy_n [2] = '{0, 0};
  int acc_t [2][64];
  int fall_t [2][64];
  int crise_t [2][64];
  int rsp_t [2][64];
  int rdy_t [2][64];
  logic [7:0]  rsp_d [2][64];
  logic [15:0] frame_mosi [2][64];
  int frame_rises [2][64];
  int frame_first [2][64];
  logic [15:0] fmosi [2] = '{16'h0, 16'h0};
  int frise [2] = '{0, 0};
  int ffirst [2] = '{0, 0};
  int last_rise [2] = '{-1, -1};
  int slv_idx [2] = '{16, 16};
  logic [15:0] slv_pat [2] = '{16'h0, 16'h0};
  int viol [2] = '{0, 0};
  int busy_bad [2] = '{0, 0};
  int period_bad [2] = '{0, 0};
  int tail_bad [2] = '{0, 0};
  logic [1:0] prev_cs = 2'b11;
  logic [1:0] prev_sclk = 2'b00;
  logic [1:0] prev_rdy = 2'b11;

  // Slave MISO frames, written by the stimulus, indexed by cs_n falling-edge number.
  logic [15:0] slv_tab [2][64];
  logic [7:0]  model_rd [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cmd_valid[i] && cmd_ready[i]) begin acc_t[i][acc_n[i]] = cyc; acc_n[i]++; end
      if (prev_cs[i] && !cs_n[i]) begin
        fall_t[i][fall_n[i]] = cyc;
        slv_pat[i] = slv_tab[i][fall_n[i]];
        fall_n[i]++;
        slv_idx[i] = 0; frise[i] = 0; last_rise[i] = -1; fmosi[i] = 16'h0; ffirst[i] = 0;
      end
      if (!prev_cs[i] && cs_n[i]) begin
        crise_t[i][crise_n[i]] = cyc;
        frame_mosi[i][crise_n[i]] = fmosi[i];
        frame_rises[i][crise_n[i]] = frise[i];
        frame_first[i][crise_n[i]] = ffirst[i];
        crise_n[i]++;
      end
      if ((cs_n[i] !== prev_cs[i]) && (sclk[i] || prev_sclk[i])) viol[i]++;
      if (cs_n[i] && sclk[i]) viol[i]++;
      if (!prev_sclk[i] && sclk[i]) begin
        if (frise[i] == 0) ffirst[i] = cyc;
        if (last_rise[i] >= 0 && (cyc - last_rise[i]) != 2 * dv(i)) period_bad[i]++;
        last_rise[i] = cyc;
        fmosi[i] = {fmosi[i][14:0], mosi[i]};
        frise[i]++;
      end
      if (prev_sclk[i] && !sclk[i]) slv_idx[i]++;
      if (!cs_n[i] && !sclk[i] && frise[i] == 16 && mosi[i]) tail_bad[i]++;
      if (rsp_valid[i]) begin
        rsp_t[i][rsp_n[i]] = cyc; rsp_d[i][rsp_n[i]] = rsp_rdata[i]; rsp_n[i]++;
      end
      if (!prev_rdy[i] && cmd_ready[i]) begin rdy_t[i][rdy_n[i]] = cyc; rdy_n[i]++; end
      if (busy[i] !== ~cmd_ready[i]) busy_bad[i]++;
      miso[i] = (slv_idx[i] < 16) ? slv_pat[i][15 - slv_idx[i]] : 1'b0;
      prev_cs[i] = cs_n[i]; prev_sclk[i] = sclk[i]; prev_rdy[i] = cmd_ready[i];
    end
  end

  task automatic chk(input int i, input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL d%0d_%s observed=%0h expected=%0h", i, name, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic run(input int i, input logic rw, input logic [6:0] a, input logic [7:0] w,
                     input logic [7:0] rbyte);
    int d, ba, bf, bc, br, by, t, n;
    logic [15:0] e;
    d = dv(i);
    ba = acc_n[i]; bf = fall_n[i]; bc = crise_n[i]; br = rsp_n[i]; by = rdy_n[i];
    slv_tab[i][bf] = {8'($urandom), rbyte};
    cmd_rw[i] = rw; cmd_addr[i] = a; cmd_wdata[i] = w; cmd_valid[i] = 1'b1;
    n = 0;
    do begin tick(1); n++; end while (acc_n[i] == ba && n < 50);
    cmd_valid[i] = 1'b0;
    n = 0;
    do begin tick(1); n++; end while (rdy_n[i] == by && n < 40 * d + 20);
    tick(2);
    t = acc_t[i][ba];
    e = {rw, a, rw ? 8'h00 : w};
    if (rw) model_rd[i] = rbyte;
    chk(i, "accepts", acc_n[i] - ba, 1);
    chk(i, "sclk_rises", frame_rises[i][bc], 16);
    chk(i, "mosi_frame", {16'h0, frame_mosi[i][bc]}, {16'h0, e});
    chk(i, "cs_fall_t", fall_t[i][bf] - t, 1);
    chk(i, "first_rise_t", frame_first[i][bc] - t, 1 + d);
    chk(i, "cs_rise_t", crise_t[i][bc] - t, 1 + 33 * d);
    chk(i, "rsp_count", rsp_n[i] - br, 1);
    chk(i, "rsp_t", rsp_t[i][br] - t, 1 + 33 * d);
    chk(i, "rsp_data", {24'h0, rsp_d[i][br]}, {24'h0, model_rd[i]});
    chk(i, "ready_t", rdy_t[i][by] - t, 1 + 34 * d);
    chk(i, "rdata_hold", {24'h0, rsp_rdata[i]}, {24'h0, model_rd[i]});
  endtask

  initial begin
    int n, ba, bf, bc, br, by;
    logic [7:0] r1, r2;
    model_rd[0] = 8'h00; model_rd[1] = 8'h00;
    tick(3);
    for (int i = 0; i < 2; i++) begin
      chk(i, "rst_sclk", {31'h0, sclk[i]}, 0);
      chk(i, "rst_cs_n", {31'h0, cs_n[i]}, 1);
      chk(i, "rst_mosi", {31'h0, mosi[i]}, 0);
      chk(i, "rst_ready", {31'h0, cmd_ready[i]}, 1);
      chk(i, "rst_busy", {31'h0, busy[i]}, 0);
      chk(i, "rst_rsp_valid", {31'h0, rsp_valid[i]}, 0);
      chk(i, "rst_rdata", {24'h0, rsp_rdata[i]}, 0);
    end
    reset_n = 1'b1;
    tick(2);

    // Directed write, read, then write with MISO all ones.
    run(0, 1'b0, 7'h06, 8'hA5, 8'h5A);
    run(0, 1'b1, 7'h01, 8'($urandom), 8'hC0);
    run(0, 1'b0, 7'($urandom), 8'($urandom), 8'hFF);

    // Back-to-back reads with cmd_valid held high.
    r1 = 8'($urandom); r2 = 8'($urandom);
    ba = acc_n[0]; bf = fall_n[0]; bc = crise_n[0]; br = rsp_n[0]; by = rdy_n[0];
    slv_tab[0][bf] = {8'($urandom), r1};
    slv_tab[0][bf + 1] = {8'($urandom), r2};
    cmd_rw[0] = 1'b1; cmd_addr[0] = 7'h08; cmd_wdata[0] = 8'($urandom); cmd_valid[0] = 1'b1;
    n = 0;
    do begin tick(1); n++; end while (acc_n[0] == ba && n < 50);
    cmd_addr[0] = 7'h09;
    n = 0;
    do begin tick(1); n++; end while (acc_n[0] < ba + 2 && n < 200);
    cmd_valid[0] = 1'b0;
    n = 0;
    do begin tick(1); n++; end while (rdy_n[0] < by + 2 && n < 400);
    tick(2);
    chk(0, "b2b_accepts", acc_n[0] - ba, 2);
    chk(0, "b2b_spacing", acc_t[0][ba + 1] - acc_t[0][ba], 34 * 4 + 1);
    chk(0, "b2b_cs_gap", fall_t[0][bf + 1] - crise_t[0][bc], 4 + 1);
    chk(0, "b2b_rsp_count", rsp_n[0] - br, 2);
    chk(0, "b2b_rsp0", {24'h0, rsp_d[0][br]}, {24'h0, r1});
    chk(0, "b2b_rsp1", {24'h0, rsp_d[0][br + 1]}, {24'h0, r2});
    chk(0, "b2b_rsp1_t", rsp_t[0][br + 1] - acc_t[0][ba + 1], 1 + 33 * 4);
    chk(0, "b2b_mosi1", {16'h0, frame_mosi[0][bc + 1]}, {16'h0, 1'b1, 7'h09, 8'h00});
    model_rd[0] = r2;

    // Reset during the low phase of bit k=5.
    br = rsp_n[0]; bf = fall_n[0]; ba = acc_n[0];
    slv_tab[0][bf] = 16'($urandom);
    cmd_rw[0] = 1'b1; cmd_addr[0] = 7'($urandom); cmd_valid[0] = 1'b1;
    n = 0;
    do begin tick(1); n++; end while (acc_n[0] == ba && n < 50);
    cmd_valid[0] = 1'b0;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!(frise[0] == 5 && !sclk[0]) && n < 300);
    chk(0, "reset_point_bit", frise[0], 5);
    reset_n = 1'b0;
    #1;
    chk(0, "mid_rst_cs_n", {31'h0, cs_n[0]}, 1);
    chk(0, "mid_rst_sclk", {31'h0, sclk[0]}, 0);
    chk(0, "mid_rst_ready", {31'h0, cmd_ready[0]}, 1);
    chk(0, "mid_rst_busy", {31'h0, busy[0]}, 0);
    chk(0, "mid_rst_mosi", {31'h0, mosi[0]}, 0);
    @(posedge clk); #2;
    tick(1);
    reset_n = 1'b1;
    model_rd[0] = 8'h00; model_rd[1] = 8'h00;
    tick(150);
    chk(0, "abort_no_rsp", rsp_n[0] - br, 0);
    chk(0, "abort_rdata", {24'h0, rsp_rdata[0]}, 0);
    run(0, 1'b1, 7'($urandom), 8'($urandom), 8'($urandom));

    // CLK_DIV=1 instance.
    run(1, 1'b0, 7'h07, 8'h3C, 8'($urandom));
    for (int k = 0; k < 6; k++)
      run(1, 1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom));
    for (int k = 0; k < 4; k++)
      run(0, 1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom));

    for (int i = 0; i < 2; i++) begin
      chk(i, "sclk_cs_rules", viol[i], 0);
      chk(i, "busy_eq_not_ready", busy_bad[i], 0);
      chk(i, "sclk_period", period_bad[i], 0);
      chk(i, "mosi_zero_after_last_fall", tail_bad[i], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
